operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 207 ++++++++++++++++++++
 tb/tb_operand_fetch.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
// Purpose : Accepts decoded instructions, reads their source operands from a
//           registered-read register file, merges in-flight writebacks so that
//           operands are never stale, and holds the result for the consumer.
// Ports   :
//   clk_i, resetn_i            clock, asynchronous active-low reset
//   dec_*                      decode-side handshake and register addresses
//   wb_*                       writeback bus (also forwarded to the RF)
//   rf_*                       register-file read request/data and write port
//   op_*                       downstream operand handshake and payload
// -----------------------------------------------------------------------------
module operand_fetch #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk_i,
   input  logic                  resetn_i,
   // decode side
   input  logic                  dec_valid_i,
   output logic                  dec_ready_o,
   input  logic [REG_ADDR_W-1:0] dec_rs1_i,
   input  logic [REG_ADDR_W-1:0] dec_rs2_i,
   input  logic [REG_ADDR_W-1:0] dec_rd_i,
   input  logic                  dec_use_rs1_i,
   input  logic                  dec_use_rs2_i,
   // writeback
   input  logic                  wb_valid_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_i,
   input  logic [XLEN-1:0]       wb_data_i,
   // register file
   output logic                  rf_read_en_o,
   output logic [REG_ADDR_W-1:0] rf_rs1_addr_o,
   output logic [REG_ADDR_W-1:0] rf_rs2_addr_o,
   input  logic [XLEN-1:0]       rf_rs1_data_i,
   input  logic [XLEN-1:0]       rf_rs2_data_i,
   output logic                  rf_rd_write_en_o,
   output logic [REG_ADDR_W-1:0] rf_rd_addr_o,
   output logic [XLEN-1:0]       rf_rd_data_o,
   // downstream
   output logic                  op_valid_o,
   input  logic                  op_ready_i,
   output logic [XLEN-1:0]       op_rs1_data_o,
   output logic [XLEN-1:0]       op_rs2_data_o,
   output logic [REG_ADDR_W-1:0] op_rs1_o,
   output logic [REG_ADDR_W-1:0] op_rs2_o,
   output logic [REG_ADDR_W-1:0] op_rd_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t                r_state;

   // instruction latched at accept
   logic [REG_ADDR_W-1:0] r_rs1;
   logic [REG_ADDR_W-1:0] r_rs2;
   logic [REG_ADDR_W-1:0] r_rd;
   logic                  r_use1;
   logic                  r_use2;

   // writeback seen in the accept cycle; the RF read launched that cycle misses it
   logic                  r_byp1_vld;
   logic                  r_byp2_vld;
   logic [XLEN-1:0]       r_byp1_data;
   logic [XLEN-1:0]       r_byp2_data;

   // downstream payload
   logic                  r_op_valid;
   logic [XLEN-1:0]       r_op_rs1_data;
   logic [XLEN-1:0]       r_op_rs2_data;
   logic [REG_ADDR_W-1:0] r_op_rs1;
   logic [REG_ADDR_W-1:0] r_op_rs2;
   logic [REG_ADDR_W-1:0] r_op_rd;

   logic                  w_dec_ready;
   logic                  w_accept;
   logic                  w_wb_live;
   logic                  w_acc_hit1;
   logic                  w_acc_hit2;
   logic                  w_rd_hit1;
   logic                  w_rd_hit2;
   logic                  w_hold_hit1;
   logic                  w_hold_hit2;
   logic [XLEN-1:0]       w_sel1;
   logic [XLEN-1:0]       w_sel2;

   // Operand priority: unused/x0 -> 0, live writeback, stored bypass, RF data
   function automatic logic [XLEN-1:0] f_sel(
      input logic                  i_used,
      input logic [REG_ADDR_W-1:0] i_addr,
      input logic                  i_wb_hit,
      input logic [XLEN-1:0]       i_wb_data,
      input logic                  i_byp_vld,
      input logic [XLEN-1:0]       i_byp_data,
      input logic [XLEN-1:0]       i_rf_data
   );
      logic [XLEN-1:0] v_res;
      if (!i_used || (i_addr == '0)) v_res = '0;
      else if (i_wb_hit)             v_res = i_wb_data;
      else if (i_byp_vld)            v_res = i_byp_data;
      else                           v_res = i_rf_data;
      return v_res;
   endfunction

   // Handshake; gated by reset so nothing is requested while held in reset
   assign w_dec_ready = resetn_i &&
                        ((r_state == S_IDLE) || ((r_state == S_HOLD) && op_ready_i));
   assign w_accept    = dec_valid_i && w_dec_ready;

   // Writeback match qualifiers (x0 never matches)
   assign w_wb_live   = wb_valid_i && (wb_rd_i != '0);
   assign w_acc_hit1  = w_wb_live && (wb_rd_i == dec_rs1_i);
   assign w_acc_hit2  = w_wb_live && (wb_rd_i == dec_rs2_i);
   assign w_rd_hit1   = w_wb_live && (wb_rd_i == r_rs1);
   assign w_rd_hit2   = w_wb_live && (wb_rd_i == r_rs2);
   assign w_hold_hit1 = w_wb_live && r_use1 && (wb_rd_i == r_op_rs1);
   assign w_hold_hit2 = w_wb_live && r_use2 && (wb_rd_i == r_op_rs2);

   assign w_sel1 = f_sel(r_use1, r_rs1, w_rd_hit1, wb_data_i,
                         r_byp1_vld, r_byp1_data, rf_rs1_data_i);
   assign w_sel2 = f_sel(r_use2, r_rs2, w_rd_hit2, wb_data_i,
                         r_byp2_vld, r_byp2_data, rf_rs2_data_i);

   // FSM, instruction latch and operand registers
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_state       <= S_IDLE;
         r_rs1         <= '0;
         r_rs2         <= '0;
         r_rd          <= '0;
         r_use1        <= 1'b0;
         r_use2        <= 1'b0;
         r_byp1_vld    <= 1'b0;
         r_byp2_vld    <= 1'b0;
         r_byp1_data   <= '0;
         r_byp2_data   <= '0;
         r_op_valid    <= 1'b0;
         r_op_rs1_data <= '0;
         r_op_rs2_data <= '0;
         r_op_rs1      <= '0;
         r_op_rs2      <= '0;
         r_op_rd       <= '0;
      end else begin
         if (w_accept) begin
            r_rs1       <= dec_rs1_i;
            r_rs2       <= dec_rs2_i;
            r_rd        <= dec_rd_i;
            r_use1      <= dec_use_rs1_i;
            r_use2      <= dec_use_rs2_i;
            r_byp1_vld  <= w_acc_hit1;
            r_byp2_vld  <= w_acc_hit2;
            r_byp1_data <= wb_data_i;
            r_byp2_data <= wb_data_i;
         end

         case (r_state)
            S_IDLE: begin
               if (w_accept) r_state <= S_READ;
            end
            S_READ: begin
               r_op_valid    <= 1'b1;
               r_op_rs1_data <= w_sel1;
               r_op_rs2_data <= w_sel2;
               r_op_rs1      <= r_rs1;
               r_op_rs2      <= r_rs2;
               r_op_rd       <= r_rd;
               r_state       <= S_HOLD;
            end
            S_HOLD: begin
               if (op_ready_i) begin
                  r_op_valid <= 1'b0;
                  r_state    <= w_accept ? S_READ : S_IDLE;
               end else begin
                  // keep held operands coherent with late writebacks
                  if (w_hold_hit1) r_op_rs1_data <= wb_data_i;
                  if (w_hold_hit2) r_op_rs2_data <= wb_data_i;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dec_ready_o      = w_dec_ready;

   // RF read request only in the accept cycle; addresses otherwise hold
   assign rf_read_en_o     = w_accept;
   assign rf_rs1_addr_o    = w_accept ? dec_rs1_i : r_rs1;
   assign rf_rs2_addr_o    = w_accept ? dec_rs2_i : r_rs2;

   // Writeback passthrough, independent of FSM and reset
   assign rf_rd_write_en_o = w_wb_live;
   assign rf_rd_addr_o     = wb_rd_i;
   assign rf_rd_data_o     = wb_data_i;

   assign op_valid_o       = r_op_valid;
   assign op_rs1_data_o    = r_op_rs1_data;
   assign op_rs2_data_o    = r_op_rs2_data;
   assign op_rs1_o         = r_op_rs1;
   assign op_rs2_o         = r_op_rs2;
   assign op_rd_o          = r_op_rd;

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
// Purpose : Directed self-checking bench for operand_fetch with a registered-
//           read register-file model and an expected-operand scoreboard.
// -----------------------------------------------------------------------------
module tb_operand_fetch;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;

   typedef struct {
      logic [XLEN-1:0] d1;
      logic [XLEN-1:0] d2;
      logic [AW-1:0]   rs1;
      logic [AW-1:0]   rs2;
      logic [AW-1:0]   rd;
   } exp_t;

   logic            clk_i = 1'b0;
   logic            resetn_i;
   logic            dec_valid_i;
   logic            dec_ready_o;
   logic [AW-1:0]   dec_rs1_i, dec_rs2_i, dec_rd_i;
   logic            dec_use_rs1_i, dec_use_rs2_i;
   logic            wb_valid_i;
   logic [AW-1:0]   wb_rd_i;
   logic [XLEN-1:0] wb_data_i;
   logic            rf_read_en_o;
   logic [AW-1:0]   rf_rs1_addr_o, rf_rs2_addr_o;
   logic [XLEN-1:0] rf_rs1_data_i, rf_rs2_data_i;
   logic            rf_rd_write_en_o;
   logic [AW-1:0]   rf_rd_addr_o;
   logic [XLEN-1:0] rf_rd_data_o;
   logic            op_valid_o;
   logic            op_ready_i;
   logic [XLEN-1:0] op_rs1_data_o, op_rs2_data_o;
   logic [AW-1:0]   op_rs1_o, op_rs2_o, op_rd_o;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];

   operand_fetch #(.XLEN(XLEN), .REG_ADDR_W(AW)) dut (
      .clk_i(clk_i), .resetn_i(resetn_i),
      .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
      .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
      .dec_use_rs1_i(dec_use_rs1_i), .dec_use_rs2_i(dec_use_rs2_i),
      .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
      .rf_read_en_o(rf_read_en_o), .rf_rs1_addr_o(rf_rs1_addr_o),
      .rf_rs2_addr_o(rf_rs2_addr_o), .rf_rs1_data_i(rf_rs1_data_i),
      .rf_rs2_data_i(rf_rs2_data_i), .rf_rd_write_en_o(rf_rd_write_en_o),
      .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_data_o(rf_rd_data_o),
      .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
      .op_rs1_data_o(op_rs1_data_o), .op_rs2_data_o(op_rs2_data_o),
      .op_rs1_o(op_rs1_o), .op_rs2_o(op_rs2_o), .op_rd_o(op_rd_o)
   );

   always #5 clk_i = ~clk_i;

   // Register file model: registered read returns pre-write contents
   logic [XLEN-1:0] rf_mem [32];
   always @(posedge clk_i) begin
      if (rf_rd_write_en_o) rf_mem[rf_rd_addr_o] <= rf_rd_data_o;
      if (rf_read_en_o) begin
         rf_rs1_data_i <= rf_mem[rf_rs1_addr_o];
         rf_rs2_data_i <= rf_mem[rf_rs2_addr_o];
      end
   end

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   // Drive one accepted instruction (optionally with a writeback the same cycle)
   task automatic do_accept(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                            input logic [AW-1:0] rd, input logic u1, input logic u2,
                            input logic wbv, input logic [AW-1:0] wbrd,
                            input logic [XLEN-1:0] wbd);
      dec_valid_i = 1'b1; dec_rs1_i = rs1; dec_rs2_i = rs2; dec_rd_i = rd;
      dec_use_rs1_i = u1; dec_use_rs2_i = u2;
      wb_valid_i = wbv; wb_rd_i = wbrd; wb_data_i = wbd;
      @(negedge clk_i);
      chk1("acc_dec_ready", dec_ready_o, 1'b1);
      chk1("acc_rf_read_en", rf_read_en_o, 1'b1);
      chk("acc_rf_rs1_addr", XLEN'(rf_rs1_addr_o), XLEN'(rs1));
      chk("acc_rf_rs2_addr", XLEN'(rf_rs2_addr_o), XLEN'(rs2));
      chk1("acc_rf_wr_en", rf_rd_write_en_o, wbv && (wbrd != '0));
      next_cycle();
      dec_valid_i = 1'b0;
      wb_valid_i  = 1'b0;
   endtask

   // Bounded wait for op_valid_o; checks how many extra cycles it took
   task automatic wait_valid(input string tag, input int exp_wait);
      int n = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         if (op_valid_o === 1'b1) begin
            n = i;
            break;
         end
         next_cycle();
      end
      chk({tag, "_latency"}, XLEN'(n), XLEN'(exp_wait));
   endtask

   // Compare the presented operands against the oldest scoreboard entry
   task automatic pop_check(input string tag);
      exp_t e;
      n_checks++;
      assert (sb_q.size() > 0) else begin
         n_errors++;
         $error("FAIL %s_sb_empty: observed 0 entries expected 1", tag);
      end
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk1({tag, "_valid"}, op_valid_o, 1'b1);
         chk({tag, "_rs1_data"}, op_rs1_data_o, e.d1);
         chk({tag, "_rs2_data"}, op_rs2_data_o, e.d2);
         chk({tag, "_rs1"}, XLEN'(op_rs1_o), XLEN'(e.rs1));
         chk({tag, "_rs2"}, XLEN'(op_rs2_o), XLEN'(e.rs2));
         chk({tag, "_rd"}, XLEN'(op_rd_o), XLEN'(e.rd));
      end
   endtask

   initial begin
      resetn_i = 1'b0; dec_valid_i = 1'b0; dec_rs1_i = '0; dec_rs2_i = '0;
      dec_rd_i = '0; dec_use_rs1_i = 1'b0; dec_use_rs2_i = 1'b0;
      wb_valid_i = 1'b0; wb_rd_i = '0; wb_data_i = '0; op_ready_i = 1'b1;

      // Reset state; writeback passthrough preloads x5/x6 while in reset
      next_cycle();
      dec_valid_i = 1'b1;
      wb_valid_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h11;
      @(negedge clk_i);
      chk1("rst_op_valid", op_valid_o, 1'b0);
      chk1("rst_dec_ready", dec_ready_o, 1'b0);
      chk1("rst_rf_read_en", rf_read_en_o, 1'b0);
      chk("rst_op_rs1_data", op_rs1_data_o, '0);
      chk("rst_op_rd", XLEN'(op_rd_o), '0);
      chk1("rst_wb_en", rf_rd_write_en_o, 1'b1);
      chk("rst_wb_addr", XLEN'(rf_rd_addr_o), 32'd5);
      chk("rst_wb_data", rf_rd_data_o, 32'h11);
      next_cycle();
      dec_valid_i = 1'b0;
      wb_rd_i = 5'd6; wb_data_i = 32'h22;
      next_cycle();
      wb_valid_i = 1'b0;
      next_cycle();
      resetn_i = 1'b1;

      // Plain fetch with cycle-accurate latency and address hold
      sb_q.push_back('{32'h11, 32'h22, 5'd5, 5'd6, 5'd7});
      do_accept(5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0, '0, '0);
      @(negedge clk_i);
      chk1("plain_read_valid", op_valid_o, 1'b0);
      chk1("plain_read_dec_ready", dec_ready_o, 1'b0);
      chk1("plain_read_rf_en", rf_read_en_o, 1'b0);
      chk("plain_read_addr_hold", XLEN'(rf_rs1_addr_o), 32'd5);
      next_cycle();
      wait_valid("plain", 0);
      pop_check("plain");
      next_cycle();
      @(negedge clk_i);
      chk1("plain_idle_valid", op_valid_o, 1'b0);
      chk1("plain_idle_ready", dec_ready_o, 1'b1);
      next_cycle();

      // Accept-cycle bypass: RF still returns 0x11 for x5
      sb_q.push_back('{32'hAAAA, 32'h22, 5'd5, 5'd6, 5'd8});
      do_accept(5'd5, 5'd6, 5'd8, 1'b1, 1'b1, 1'b1, 5'd5, 32'hAAAA);
      wait_valid("accbyp", 1);
      pop_check("accbyp");
      next_cycle();

      // READ-cycle writeback beats the accept-cycle one
      sb_q.push_back('{32'hAAAA, 32'hBEEF, 5'd5, 5'd6, 5'd9});
      do_accept(5'd5, 5'd6, 5'd9, 1'b1, 1'b1, 1'b1, 5'd6, 32'h1234);
      wb_valid_i = 1'b1; wb_rd_i = 5'd6; wb_data_i = 32'hBEEF;
      @(negedge clk_i);
      chk1("rdbyp_read_valid", op_valid_o, 1'b0);
      next_cycle();
      wb_valid_i = 1'b0;
      wait_valid("rdbyp", 0);
      pop_check("rdbyp");
      next_cycle();

      // x0 source and unused source both read as zero; x0 write dropped
      sb_q.push_back('{32'h0, 32'h0, 5'd0, 5'd6, 5'd10});
      do_accept(5'd0, 5'd6, 5'd10, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF);
      wait_valid("x0", 1);
      pop_check("x0");
      next_cycle();

      // Backpressure for five HOLD cycles with a late writeback to x5
      op_ready_i = 1'b0;
      sb_q.push_back('{32'h77, 32'hBEEF, 5'd5, 5'd6, 5'd11});
      do_accept(5'd5, 5'd6, 5'd11, 1'b1, 1'b1, 1'b0, '0, '0);
      wait_valid("bp", 1);
      dec_valid_i = 1'b1; dec_rs1_i = 5'd3; dec_rs2_i = 5'd4; dec_rd_i = 5'd2;
      for (int h = 1; h <= 5; h++) begin
         if (h > 1) begin
            next_cycle();
            wb_valid_i = (h == 3); wb_rd_i = 5'd5; wb_data_i = 32'h77;
            @(negedge clk_i);
         end
         chk1("bp_dec_ready", dec_ready_o, 1'b0);
         chk1("bp_rf_read_en", rf_read_en_o, 1'b0);
         chk1("bp_valid", op_valid_o, 1'b1);
         chk("bp_rd", XLEN'(op_rd_o), 32'd11);
         chk("bp_rs2_data", op_rs2_data_o, 32'hBEEF);
         chk("bp_rs1_data", op_rs1_data_o, (h <= 3) ? 32'hAAAA : 32'h77);
      end
      next_cycle();
      dec_valid_i = 1'b0;
      op_ready_i  = 1'b1;
      @(negedge clk_i);
      chk1("bp_release_ready", dec_ready_o, 1'b1);
      pop_check("bp");
      next_cycle();
      @(negedge clk_i);
      chk1("bp_done_valid", op_valid_o, 1'b0);
      next_cycle();

      // rs1 == rs2 bypass identically
      sb_q.push_back('{32'h5555, 32'h5555, 5'd6, 5'd6, 5'd13});
      do_accept(5'd6, 5'd6, 5'd13, 1'b1, 1'b1, 1'b1, 5'd6, 32'h5555);
      wait_valid("same", 1);
      pop_check("same");
      next_cycle();

      // Back-to-back: new accept in the HOLD cycle that retires the previous
      sb_q.push_back('{32'h77, 32'h5555, 5'd5, 5'd6, 5'd14});
      do_accept(5'd5, 5'd6, 5'd14, 1'b1, 1'b1, 1'b0, '0, '0);
      next_cycle();
      dec_valid_i = 1'b1; dec_rs1_i = 5'd6; dec_rs2_i = 5'd5; dec_rd_i = 5'd15;
      dec_use_rs1_i = 1'b1; dec_use_rs2_i = 1'b1;
      @(negedge clk_i);
      chk1("b2b_dec_ready", dec_ready_o, 1'b1);
      chk1("b2b_rf_read_en", rf_read_en_o, 1'b1);
      pop_check("b2b_a");
      sb_q.push_back('{32'h5555, 32'h77, 5'd6, 5'd5, 5'd15});
      next_cycle();
      dec_valid_i = 1'b0;
      @(negedge clk_i);
      chk1("b2b_gap_valid", op_valid_o, 1'b0);
      next_cycle();
      wait_valid("b2b_b", 0);
      pop_check("b2b_b");
      next_cycle();

      // Async reset between edges in HOLD discards the instruction
      op_ready_i = 1'b0;
      do_accept(5'd5, 5'd6, 5'd12, 1'b1, 1'b1, 1'b0, '0, '0);
      wait_valid("rst_hold", 1);
      #2;
      resetn_i = 1'b0;
      #1;
      chk1("mid_rst_valid", op_valid_o, 1'b0);
      chk("mid_rst_rs1_data", op_rs1_data_o, '0);
      chk("mid_rst_rd", XLEN'(op_rd_o), '0);
      chk1("mid_rst_rf_en", rf_read_en_o, 1'b0);
      next_cycle();
      resetn_i   = 1'b1;
      op_ready_i = 1'b1;
      sb_q.push_back('{32'h77, 32'h5555, 5'd5, 5'd6, 5'd7});
      do_accept(5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0, '0, '0);
      wait_valid("post_rst", 1);
      pop_check("post_rst");
      next_cycle();

      chk("sb_drained", XLEN'(sb_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
